// File: rtl/rocev2_mem_pkg.sv
// Shared types and helpers for the RoCEv2 memory read responder.
package rocev2_mem_pkg;
  localparam int MEM_CMD_W  = 96;
  localparam int MEM_DATA_W = 512;
  localparam int MEM_KEEP_W = 64;

  typedef struct packed {
    logic [31:0] len;
    logic [63:0] addr;
  } mem_cmd_t;

  typedef enum logic {ST_IDLE, ST_RUN} rsp_state_e;

  // Byte enables for a final beat carrying rem bytes; rem==0 means a full beat.
  function automatic logic [MEM_KEEP_W-1:0] keep_from_rem(input logic [5:0] rem);
    logic [MEM_KEEP_W-1:0] k;
    k = '1;
    if (rem != 6'd0) k = (MEM_KEEP_W'(1) << rem) - MEM_KEEP_W'(1);
    return k;
  endfunction
endpackage

// File: rtl/rocev2_axis_skid2.sv
// Two-entry valid/ready skid buffer with a registered output stage.
module rocev2_axis_skid2 #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         in_ready_o,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o,
  output logic [1:0]   count_o
);
  logic         out_vld_q, skid_vld_q;
  logic [W-1:0] out_data_q, skid_data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_vld_q   <= 1'b0;
      skid_vld_q  <= 1'b0;
      out_data_q  <= '0;
      skid_data_q <= '0;
    end else if (!out_vld_q || out_ready_i) begin
      if (skid_vld_q) begin
        out_vld_q  <= 1'b1;
        out_data_q <= skid_data_q;
        skid_vld_q <= in_valid_i;
        if (in_valid_i) skid_data_q <= in_data_i;
      end else begin
        out_vld_q <= in_valid_i;
        if (in_valid_i) out_data_q <= in_data_i;
      end
    end else if (in_valid_i) begin
      // Output stalled: park the arriving word in the spare entry.
      skid_vld_q  <= 1'b1;
      skid_data_q <= in_data_i;
    end
  end

  assign in_ready_o  = !skid_vld_q;
  assign out_valid_o = out_vld_q;
  assign out_data_o  = out_data_q;
  assign count_o     = {out_vld_q & skid_vld_q, out_vld_q ^ skid_vld_q};
endmodule

// File: rtl/rocev2_mem_rd_responder.sv
// Memory-side responder: turns read commands into 512-bit AXIS beats from a local buffer.
// Define MEMRSP_PATTERN_EN to replace the buffer with an address-pattern generator.
module rocev2_mem_rd_responder
  import rocev2_mem_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [MEM_CMD_W-1:0]  s_axis_mem_read_cmd_tdata,
  input  logic                  s_axis_mem_read_cmd_tvalid,
  output logic                  s_axis_mem_read_cmd_tready,
  output logic [MEM_DATA_W-1:0] m_axis_mem_read_data_tdata,
  output logic [MEM_KEEP_W-1:0] m_axis_mem_read_data_tkeep,
  output logic                  m_axis_mem_read_data_tlast,
  output logic                  m_axis_mem_read_data_tvalid,
  input  logic                  m_axis_mem_read_data_tready,
  input  logic                  preload_wr_en,
  input  logic [ADDR_W-1:0]     preload_wr_addr,
  input  logic [MEM_DATA_W-1:0] preload_wr_data,
  output logic [31:0]           stat_cmd_cnt,
  output logic [31:0]           stat_unaligned_cnt
);
  localparam int SB_W = 1 + MEM_KEEP_W + MEM_DATA_W;

  mem_cmd_t        cmd;
  rsp_state_e      state_q;
  logic            init_q;
  logic [63:0]     addr_q, iss_addr;
  logic [26:0]     left_q, iss_left, cmd_beats;
  logic [5:0]      rem_q, iss_rem;
  logic [31:0]     cmd_cnt_q, una_cnt_q;
  logic            cmd_rdy, cmd_acc, iss, iss_last, credit;
  logic [MEM_KEEP_W-1:0] iss_keep, rd_keep_q;
  logic            rd_vld_q, rd_last_q;
  logic [MEM_DATA_W-1:0] rd_data_q;
  logic [1:0]      sb_cnt;
  logic            out_hs, unused_sb_rdy;
  logic [SB_W-1:0] sb_out;

  assign cmd       = s_axis_mem_read_cmd_tdata;
  assign out_hs    = m_axis_mem_read_data_tvalid & m_axis_mem_read_data_tready;
  // The next command is taken in the same cycle the final beat leaves.
  assign cmd_rdy   = init_q & ((state_q == ST_IDLE) | (out_hs & m_axis_mem_read_data_tlast));
  assign cmd_acc   = s_axis_mem_read_cmd_tvalid & cmd_rdy;
  assign cmd_beats = {1'b0, cmd.len[31:6]} + 27'(|cmd.len[5:0]);
  // Reads in flight plus buffered beats may never exceed the two skid entries.
  assign credit    = ({1'b0, sb_cnt} + {2'b0, rd_vld_q} + 3'd1) <= (3'd2 + {2'b0, out_hs});

  always_comb begin
    iss_addr = addr_q;
    iss_left = left_q;
    iss_rem  = rem_q;
    iss      = (state_q == ST_RUN) && (left_q != 27'd0) && credit;
    if (cmd_acc) begin
      iss_addr = {cmd.addr[63:6], 6'b0};
      iss_left = cmd_beats;
      iss_rem  = cmd.len[5:0];
      iss      = (cmd_beats != 27'd0);
    end
  end

  assign iss_last = (iss_left == 27'd1);
  assign iss_keep = iss_last ? keep_from_rem(iss_rem) : '1;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q   <= ST_IDLE;
      init_q    <= 1'b0;
      addr_q    <= '0;
      left_q    <= '0;
      rem_q     <= '0;
      cmd_cnt_q <= '0;
      una_cnt_q <= '0;
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
      rd_keep_q <= '0;
    end else begin
      init_q    <= 1'b1;
      rd_vld_q  <= iss;
      rd_last_q <= iss & iss_last;
      rd_keep_q <= iss_keep;
      if (cmd_acc) begin
        state_q <= (cmd_beats != 27'd0) ? ST_RUN : ST_IDLE;
        rem_q   <= cmd.len[5:0];
        if (cmd_cnt_q != '1) cmd_cnt_q <= cmd_cnt_q + 32'd1;
        if ((cmd.addr[5:0] != 6'd0) && (una_cnt_q != '1)) una_cnt_q <= una_cnt_q + 32'd1;
      end else if (out_hs & m_axis_mem_read_data_tlast) begin
        state_q <= ST_IDLE;
      end
      if (iss) begin
        addr_q <= iss_addr + 64'd64;
        left_q <= iss_left - 27'd1;
      end
    end
  end

`ifdef MEMRSP_PATTERN_EN
  logic unused_preload;
  assign unused_preload = ^{preload_wr_en, preload_wr_addr, preload_wr_data};

  always_ff @(posedge ap_clk) begin
    if (iss) rd_data_q <= {8{iss_addr}};
  end
`else
  logic [MEM_DATA_W-1:0] mem [DEPTH];
  logic unused_addr;
  assign unused_addr = ^{iss_addr[63:ADDR_W+6], iss_addr[5:0]};

  // Read-before-write: a colliding preload is seen by later reads only.
  always_ff @(posedge ap_clk) begin
    if (iss) rd_data_q <= mem[iss_addr[ADDR_W+5:6]];
    if (preload_wr_en) mem[preload_wr_addr] <= preload_wr_data;
  end
`endif

  rocev2_axis_skid2 #(.W(SB_W)) u_skid (
    .clk_i       (ap_clk),
    .rst_ni      (ap_rst_n),
    .in_valid_i  (rd_vld_q),
    .in_data_i   ({rd_last_q, rd_keep_q, rd_data_q}),
    .in_ready_o  (unused_sb_rdy),
    .out_valid_o (m_axis_mem_read_data_tvalid),
    .out_ready_i (m_axis_mem_read_data_tready),
    .out_data_o  (sb_out),
    .count_o     (sb_cnt)
  );

  assign {m_axis_mem_read_data_tlast, m_axis_mem_read_data_tkeep, m_axis_mem_read_data_tdata} = sb_out;
  assign s_axis_mem_read_cmd_tready = cmd_rdy;
  assign stat_cmd_cnt       = cmd_cnt_q;
  assign stat_unaligned_cnt = una_cnt_q;
endmodule

// File: tb/tb_rocev2_mem_rd_responder.sv
// Self-checking bench: command table, corner sequences and randomized traffic vs. a beat-list model.
module tb_rocev2_mem_rd_responder;
  localparam int DEPTH = 1024;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic [95:0]  cmd_data = '0;
  logic         cmd_valid = 1'b0, cmd_ready;
  logic [511:0] d_data;
  logic [63:0]  d_keep;
  logic         d_last, d_valid, d_ready = 1'b1;
  logic         pl_en = 1'b0;
  logic [9:0]   pl_addr = '0;
  logic [511:0] pl_data = '0;
  logic [31:0]  st_cmd, st_una;

  always #5 clk = ~clk;

  rocev2_mem_rd_responder dut (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .s_axis_mem_read_cmd_tdata(cmd_data), .s_axis_mem_read_cmd_tvalid(cmd_valid),
    .s_axis_mem_read_cmd_tready(cmd_ready),
    .m_axis_mem_read_data_tdata(d_data), .m_axis_mem_read_data_tkeep(d_keep),
    .m_axis_mem_read_data_tlast(d_last), .m_axis_mem_read_data_tvalid(d_valid),
    .m_axis_mem_read_data_tready(d_ready),
    .preload_wr_en(pl_en), .preload_wr_addr(pl_addr), .preload_wr_data(pl_data),
    .stat_cmd_cnt(st_cmd), .stat_unaligned_cnt(st_una)
  );

  typedef struct { logic [511:0] data; logic [63:0] keep; logic last; int cyc; } beat_t;
  typedef struct { logic [63:0] addr; logic [31:0] len; int nbeats; logic [63:0] last_keep; int first_word; } vec_t;

  beat_t        obs_q[$], exp_q[$];
  logic [511:0] ref_mem [DEPTH];
  int           n_chk = 0, n_fail = 0, cyc = 0, m_cmd = 0, m_una = 0;
  bit           mon_en = 1'b0;
  logic         st_prev = 1'b0;
  logic [576:0] prev_bus;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [639:0] act, input logic [639:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Records every handshake and checks that a stalled beat holds still.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (st_prev) chk("stall_stable", 640'({d_valid, d_last, d_keep, d_data}), 640'({1'b1, prev_bus}));
      if (d_valid && d_ready) obs_q.push_back('{d_data, d_keep, d_last, cyc});
      st_prev  = d_valid && !d_ready;
      prev_bus = {d_last, d_keep, d_data};
    end else begin
      st_prev = 1'b0;
    end
  end

  // Reference: a command is a list of consecutive buffer words, the last one trimmed to len.
  function automatic void model_cmd(input logic [63:0] addr, input logic [31:0] len);
    int n;
    logic [63:0] w;
    beat_t b;
    n = int'((64'(len) + 64'd63) / 64'd64);
    m_cmd++;
    if (addr % 64 != 0) m_una++;
    for (int i = 0; i < n; i++) begin
      w      = (addr / 64 + 64'(i)) % DEPTH;
      b.data = ref_mem[w[9:0]];
      b.keep = (i == n - 1 && len % 64 != 0) ? (64'd1 << (len % 64)) - 64'd1 : '1;
      b.last = (i == n - 1);
      b.cyc  = 0;
      exp_q.push_back(b);
    end
  endfunction

  task automatic send_cmd(input logic [63:0] addr, input logic [31:0] len, output int acc_cyc);
    @(posedge clk); #1;
    cmd_data  = {len, addr};
    cmd_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    chk("cmd_accepted", 640'(cmd_ready), 640'(1));
    acc_cyc = cyc;
    model_cmd(addr, len);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    @(posedge clk); #1;
    d_ready = 1'b1;
    for (int k = 0; k < 3000 && obs_q.size() < exp_q.size(); k++) begin
      @(negedge clk); #1;
    end
    repeat (4) @(negedge clk);
    #1;
    chk({nm, "_count"}, 640'(obs_q.size()), 640'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk({nm, "_beat"}, 640'({obs_q[i].last, obs_q[i].keep, obs_q[i].data}),
          640'({exp_q[i].last, exp_q[i].keep, exp_q[i].data}));
  endtask

  task automatic clear_q();
    obs_q.delete();
    exp_q.delete();
  endtask

  vec_t         vt[8];
  int           acc;
  logic [511:0] newd;

  initial begin
    vt[0] = '{64'h0,                   32'd256, 4, '1,                     0};
    vt[1] = '{64'h40,                  32'd100, 2, 64'h0000_000F_FFFF_FFFF, 1};
    vt[2] = '{64'd1023 * 64,           32'd192, 3, '1,                     1023};
    vt[3] = '{64'h0,                   32'd0,   0, '0,                     0};
    vt[4] = '{64'h45,                  32'd64,  1, '1,                     1};
    vt[5] = '{64'h80,                  32'd1,   1, 64'h1,                  2};
    vt[6] = '{64'h100,                 32'd65,  2, 64'h1,                  4};
    vt[7] = '{64'hABCD_0000_0001_0083, 32'd127, 2, 64'h7FFF_FFFF_FFFF_FFFF, 2};

    // Reset values
    #12;
    chk("rst_tvalid", 640'(d_valid), 640'(0));
    chk("rst_beat", 640'({d_last, d_keep, d_data}), 640'(0));
    chk("rst_cmd_ready", 640'(cmd_ready), 640'(0));
    chk("rst_counters", 640'({st_cmd, st_una}), 640'(0));

    // Preload the whole buffer while still idle; words 0..3 carry the A0..A3 patterns.
    for (int w = 0; w < DEPTH; w++) begin
      @(posedge clk); #1;
      pl_en   = 1'b1;
      pl_addr = 10'(w);
      pl_data = (w < 4) ? {64{8'hA0 + 8'(w)}} : {16{$urandom}};
      ref_mem[w] = pl_data;
    end
    @(posedge clk); #1;
    pl_en = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_hold_after_rst", 640'(cmd_ready), 640'(0));
    @(negedge clk);
    chk("ready_after_rst", 640'(cmd_ready), 640'(1));
    mon_en = 1'b1;

    // Table-driven commands with tready held high
    for (int v = 0; v < 8; v++) begin
      send_cmd(vt[v].addr, vt[v].len, acc);
      drain("vec");
      chk("vec_nbeats", 640'(obs_q.size()), 640'(vt[v].nbeats));
      if (vt[v].nbeats > 0 && obs_q.size() > 0) begin
        chk("vec_latency", 640'(obs_q[0].cyc - acc), 640'(2));
        chk("vec_first_data", 640'(obs_q[0].data), 640'(ref_mem[vt[v].first_word]));
        chk("vec_last_keep", 640'({obs_q[$].last, obs_q[$].keep}), 640'({1'b1, vt[v].last_keep}));
      end
      clear_q();
    end
    chk("table_cmd_cnt", 640'(st_cmd), 640'(8));
    chk("table_una_cnt", 640'(st_una), 640'(2));

    // Preload colliding with the read of the same word: old data first, new data afterwards
    newd = {16{$urandom}};
    @(posedge clk); #1;
    cmd_data  = {32'd64, 64'd20 * 64};
    cmd_valid = 1'b1;
    pl_en     = 1'b1;
    pl_addr   = 10'd20;
    pl_data   = newd;
    @(negedge clk);
    chk("coll_cmd_ready", 640'(cmd_ready), 640'(1));
    model_cmd(64'd20 * 64, 32'd64);
    @(posedge clk); #1;
    cmd_valid  = 1'b0;
    pl_en      = 1'b0;
    ref_mem[20] = newd;
    drain("coll_old");
    clear_q();
    send_cmd(64'd20 * 64, 32'd64, acc);
    drain("coll_new");
    clear_q();

    // Backpressure: tready 1010... then held low for 5 cycles
    d_ready = 1'b0;
    send_cmd(64'h200, 32'd512, acc);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      d_ready = (i % 2 == 0);
    end
    @(posedge clk); #1;
    d_ready = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("bp_valid_held", 640'(d_valid), 640'(1));
    drain("bp");
    clear_q();

    // Randomized back-to-back commands with random backpressure
    begin
      int sent = 0;
      bit pend = 1'b0;
      logic [63:0] ra;
      logic [31:0] rl;
      for (int c = 0; c < 20000 && (sent < 40 || pend); c++) begin
        @(posedge clk); #1;
        d_ready = ($urandom_range(0, 3) != 0);
        if (!pend) cmd_valid = 1'b0;
        if (!pend && sent < 40 && $urandom_range(0, 2) == 0) begin
          ra = {$urandom, $urandom};
          rl = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(1, 600));
          cmd_data  = {rl, ra};
          cmd_valid = 1'b1;
          pend      = 1'b1;
        end
        @(negedge clk);
        if (pend && cmd_ready) begin
          model_cmd(ra, rl);
          sent++;
          pend = 1'b0;
        end
      end
      chk("rand_all_sent", 640'(sent), 640'(40));
      @(posedge clk); #1;
      cmd_valid = 1'b0;
    end
    drain("rand");
    clear_q();
    chk("rand_cmd_cnt", 640'(st_cmd), 640'(m_cmd));
    chk("rand_una_cnt", 640'(st_una), 640'(m_una));

    // Reset asserted while beat 2 of 4 is presented
    send_cmd(64'h0, 32'd256, acc);
    for (int k = 0; k < 50 && obs_q.size() < 1; k++) begin
      @(negedge clk); #1;
    end
    chk("mid_beat2_valid", 640'(d_valid), 640'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tvalid", 640'(d_valid), 640'(0));
    chk("mid_rst_cmd_ready", 640'(cmd_ready), 640'(0));
    chk("mid_rst_counters", 640'({st_cmd, st_una}), 640'(0));
    clear_q();
    m_cmd = 0;
    m_una = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    send_cmd(64'h140, 32'd130, acc);
    drain("post_rst");
    chk("post_rst_nbeats", 640'(obs_q.size()), 640'(3));
    chk("post_rst_cmd_cnt", 640'(st_cmd), 640'(1));
    clear_q();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected end of test");
    $fatal(1);
  end
endmodule
